drum_mult_pipe: RTL and testbench
=================================

// Module: drum_mult_pipe
// PURPOSE
//  Pipelined, parametrised DRUM approximate multiplier with valid/ready handshake.
//  Per operand: find the leading one, keep K bits from it down, force that window's LSB to 1
//  (unbiasing), multiply K x K, then shift left by the summed offsets.
//  Next-generation datapath core: replaces the single-width combinational LOD+multiply path.
// PARAMETERS
//  N  16  operand width in bits (>= 4)
//  K  6   kept-bit window width (2 <= K <= N)
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    block accepts the pair this cycle
//  in_a       in   N    operand A (unsigned; two's complement if DRUM_SIGNED_EN)
//  in_b       in   N    operand B (same encoding as in_a)
//  out_valid  out  1    product valid
//  out_ready  in   1    downstream accepts the product
//  out_p      out  2N   approximate product (same encoding as operands)
// BEHAVIOUR
//  Reset: clock and reset are one clock, synchronous, active-high reset. On the edge with rst=1,
//   all stage valids clear and out_valid=0, out_p=0. in_ready=1 in the cycle after reset.
//   Reset mid-operation discards every in-flight pair; no partial output appears.
//  Handshake: adv = !out_valid | out_ready; in_ready = adv (global stall).
//   A transfer occurs on in_valid&in_ready. out_p is stable while out_valid & !out_ready.
//   No drop, no duplication, strict in-order delivery.
//  Latency: 3 cycles from accept to out_valid when not stalled; throughput 1 pair/cycle.
//  S1 (lod): per operand, p = index of the most-significant 1 (log2(N) bits), plus a zero flag.
//  S2 (trim): if op < 2^K then t = op[K-1:0] and s = 0 (exact).
//   Otherwise t = op[p:p-K+1] with t[0] forced to 1, and s = p-K+1.
//  S3 (mul): out_p = (t_a*t_b) << (s_a+s_b), computed at 2N width; never overflows 2N.
//  Zero operand: result is exactly 0, whatever the other operand is.
//  Both operands < 2^K: result is exact.
// CONFIGURATION
//  DRUM_SIGNED_EN defined:
//   - Operands are converted to N-bit magnitudes in S1; the N-bit magnitude holds 2^(N-1).
//   - Result sign is sign_a ^ sign_b, carried through the pipe.
//   - out_p is negated in S3 when the sign is set and the magnitude product is nonzero.
//  DRUM_SIGNED_EN undefined: operands and product are unsigned; no sign logic is built.
//  Stage count and latency are identical in both builds.
// STRUCTURE
//  Package drum_pkg: function clog2; constants IDXW = clog2(N) and SHW = clog2(2N).
//   Also holds the stage-register struct typedefs for S1 and S2 (t, s, zero, sign).
//  Sub-module lod_enc #(N): combinational leading-one detect plus binary encode -> {p, zero}.
//   Instantiated twice, in S1.
//  Top level holds the three stage registers, the valid chain and the stall logic.
// TESTING  (N=16, K=6)
//  - a=16'h00FF, b=16'h0003 -> 3 cycles later out_p = 32'd756 (exact value is 765).
//  - a=40, b=50 -> out_p=2000 (exact path); a=0, b=16'hFFFF -> out_p=0.
//  - a=b=16'hFFFF -> out_p=32'hF810_0000.
//  - in_valid held high, 10 distinct pairs, out_ready=0 for cycles 4-6:
//    in_ready drops, out_p stays frozen, all 10 results arrive in order, none lost.
//  - rst pulsed with 2 pairs in flight -> out_valid=0 next cycle, neither pair ever emitted.
//  - DRUM_SIGNED_EN: a=16'hFF01 (-255), b=3 -> out_p=32'hFFFF_FD0C (-756).
//    a=16'h8000, b=1 -> out_p = -33792.

Source files
------------

// File: rtl/drum_pkg.sv
// drum_pkg: shared widths, clog2 helper and pipeline stage records; DRUM_SIGNED_EN adds the sign bit
package drum_pkg;
    localparam int DRUM_N = 16;
    localparam int DRUM_K = 6;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    localparam int IDXW = clog2(DRUM_N);
    localparam int SHW = clog2(2 * DRUM_N);
    typedef struct packed {
        logic [DRUM_N-1:0] mag_a;
        logic [DRUM_N-1:0] mag_b;
        logic [IDXW-1:0] p_a;
        logic [IDXW-1:0] p_b;
        logic zero;
`ifdef DRUM_SIGNED_EN
        logic sign;
`endif
    } s1_t;
    typedef struct packed {
        logic [DRUM_K-1:0] t_a;
        logic [DRUM_K-1:0] t_b;
        logic [IDXW-1:0] s_a;
        logic [IDXW-1:0] s_b;
        logic zero;
`ifdef DRUM_SIGNED_EN
        logic sign;
`endif
    } s2_t;
endpackage

// File: rtl/drum_mult_pipe_if.sv
// drum_mult_pipe_if: operand/product valid-ready bus of the DRUM multiplier
interface drum_mult_pipe_if #(parameter int N = 16);
    logic in_valid;
    logic in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic out_valid;
    logic out_ready;
    logic [2*N-1:0] out_p;
    modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_p);
    modport slave (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_p);
endinterface

// File: rtl/lod_enc.sv
// lod_enc: leading-one detector with binary index and all-zero flag
module lod_enc
    import drum_pkg::*;
#(
    parameter int N = 16,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] p,
    output logic         zero
);
    // highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        p = '0;
        for (int i = 0; i < N; i++) if (d[i]) p = W'(i);
    end
    assign zero = ~|d;
endmodule

// File: rtl/drum_mult_pipe.sv
// drum_mult_pipe: 3-stage DRUM approximate multiplier (lod, trim, mul); DRUM_SIGNED_EN selects two's complement operands
module drum_mult_pipe
    import drum_pkg::*;
#(
    parameter int N = DRUM_N,
    parameter int K = DRUM_K
) (
    input logic clk,
    input logic rst,
    drum_mult_pipe_if.slave bus
);
    logic adv, v1, v2;
    logic [N-1:0] mag_a, mag_b;
    logic [IDXW-1:0] p_a, p_b;
    logic z_a, z_b;
    logic [2*N-1:0] prod, res;
    s1_t s1;
    s2_t s2;
    function automatic logic [K-1:0] trim_t(input logic [N-1:0] m, input logic [IDXW-1:0] p);
        return (int'(p) < K) ? m[K-1:0] : (K'(m >> (int'(p) - K + 1)) | K'(1));
    endfunction
    function automatic logic [IDXW-1:0] trim_s(input logic [IDXW-1:0] p);
        return (int'(p) < K) ? '0 : IDXW'(int'(p) - K + 1);
    endfunction
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
`ifdef DRUM_SIGNED_EN
    assign mag_a = bus.in_a[N-1] ? -bus.in_a : bus.in_a;
    assign mag_b = bus.in_b[N-1] ? -bus.in_b : bus.in_b;
`else
    assign mag_a = bus.in_a;
    assign mag_b = bus.in_b;
`endif
    lod_enc #(.N(N)) u_lod_a (.d(mag_a), .p(p_a), .zero(z_a));
    lod_enc #(.N(N)) u_lod_b (.d(mag_b), .p(p_b), .zero(z_b));
    assign prod = s2.zero ? '0 : ({{(2*N-K){1'b0}}, s2.t_a} * {{(2*N-K){1'b0}}, s2.t_b})
                                 << (SHW'(s2.s_a) + SHW'(s2.s_b));
`ifdef DRUM_SIGNED_EN
    assign res = (s2.sign && prod != '0) ? -prod : prod;
`else
    assign res = prod;
`endif
    // valid chain and output register; the whole pipe moves together on adv
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_p <= '0;
        end else if (adv) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            bus.out_valid <= v2;
            bus.out_p <= res;
        end
    end
    // stage data registers need no reset since their valids gate them
    always_ff @(posedge clk) begin
        if (adv) begin
            s1.mag_a <= mag_a;
            s1.mag_b <= mag_b;
            s1.p_a <= p_a;
            s1.p_b <= p_b;
            s1.zero <= z_a | z_b;
`ifdef DRUM_SIGNED_EN
            s1.sign <= bus.in_a[N-1] ^ bus.in_b[N-1];
            s2.sign <= s1.sign;
`endif
            s2.t_a <= trim_t(s1.mag_a, s1.p_a);
            s2.t_b <= trim_t(s1.mag_b, s1.p_b);
            s2.s_a <= trim_s(s1.p_a);
            s2.s_b <= trim_s(s1.p_b);
            s2.zero <= s1.zero;
        end
    end
endmodule

// File: tb/tb_drum_mult_pipe.sv
// tb_drum_mult_pipe: scoreboard bench for drum_mult_pipe (N=16, K=6), honours DRUM_SIGNED_EN
module tb_drum_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    bit rand_rdy = 0;
    logic [31:0] exp_q[$];
    drum_mult_pipe_if #(.N(16)) bif();
    drum_mult_pipe dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    function automatic longint approx(input longint m);
        int p = 0;
        int s;
        if (m < 64) return m;
        while ((m >> (p + 1)) != 0) p++;
        s = p - 5;
        return ((m >> s) | 1) << s;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        longint ma, mb, r;
        bit neg;
`ifdef DRUM_SIGNED_EN
        ma = a[15] ? 65536 - longint'(a) : longint'(a);
        mb = b[15] ? 65536 - longint'(b) : longint'(b);
        neg = a[15] ^ b[15];
`else
        ma = longint'(a);
        mb = longint'(b);
        neg = 0;
`endif
        r = approx(ma) * approx(mb);
        if (neg) r = -r;
        return r[31:0];
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] edges[4] = '{16'hFFFF, 16'h8000, 16'd64, 16'd63};
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(0, 63));
            1: return 16'($urandom);
            2: return $urandom_range(0, 1) ? 16'd0 : edges[$urandom_range(0, 3)];
            default: return 16'($urandom_range(64, 4095));
        endcase
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
        int n = 0;
        bif.in_valid = 1'b1;
        bif.in_a = a;
        bif.in_b = b;
        forever begin
            @(negedge clk);
            if (bif.in_ready) begin
                exp_q.push_back(e);
                break;
            end
            if (++n > 100) begin
                $display("FAIL send_timeout a=%h b=%h", a, b);
                errors++;
                break;
            end
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    // out_ready randomiser, active only during the random phase
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bif.out_ready = ($urandom_range(0, 3) != 0);
    end

    // monitor: pop and compare on every output transfer, check freeze and stall behaviour
    initial begin
        logic held_v = 1'b0;
        logic [31:0] held_p = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v && bif.out_valid) begin
                    checks++;
                    if (bif.out_p !== held_p) begin
                        $display("FAIL frozen_out_p got=%h want=%h", bif.out_p, held_p);
                        errors++;
                    end
                end
                if (bif.out_valid && !bif.out_ready) begin
                    checks++;
                    if (bif.in_ready !== 1'b0) begin
                        $display("FAIL stall_in_ready got=%b want=0", bif.in_ready);
                        errors++;
                    end
                end
                if (bif.out_valid && bif.out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_output got=%h want=none", bif.out_p);
                        errors++;
                    end else begin
                        e = exp_q.pop_front();
                        if (bif.out_p !== e) begin
                            $display("FAIL product got=%h want=%h", bif.out_p, e);
                            errors++;
                        end
                    end
                end
                held_v = bif.out_valid && !bif.out_ready;
                held_p = bif.out_p;
            end
        end
    end

    initial begin
        logic [15:0] a, b;
        int n;
        bif.in_valid = 1'b0;
        bif.in_a = '0;
        bif.in_b = '0;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (bif.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b want=0", bif.out_valid); errors++; end
        if (bif.out_p !== 32'd0) begin $display("FAIL reset_out_p got=%h want=0", bif.out_p); errors++; end
        if (bif.in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b want=1", bif.in_ready); errors++; end
        @(posedge clk);
        #1;
        // directed examples
        send(16'h00FF, 16'h0003, 32'd756);
        send(16'd40, 16'd50, 32'd2000);
        send(16'd0, 16'hFFFF, 32'd0);
`ifdef DRUM_SIGNED_EN
        send(16'hFFFF, 16'hFFFF, 32'd1);
        send(16'hFF01, 16'h0003, 32'hFFFF_FD0C);
        send(16'h8000, 16'h0001, 32'hFFFF_7C00);
`else
        send(16'hFFFF, 16'hFFFF, 32'hF810_0000);
`endif
        // 10 back-to-back pairs with a 3-cycle downstream stall
        fork
            for (int i = 0; i < 10; i++) begin
                a = 16'(16'h0101 * (i + 1) + 16'h0400 * i);
                b = 16'(16'd77 + 16'h0913 * i);
                send(a, b, model(a, b));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bif.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bif.out_ready = 1'b1;
            end
        join
        // reset with two pairs in flight: both must vanish
        send(16'h1234, 16'h0F0F, 32'd0);
        send(16'h00AA, 16'h0055, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bif.out_valid !== 1'b0) begin $display("FAIL flush_out_valid got=%b want=0", bif.out_valid); errors++; end
        if (bif.in_ready !== 1'b1) begin $display("FAIL flush_in_ready got=%b want=1", bif.in_ready); errors++; end
        repeat (5) @(posedge clk);
        #1;
        // randomized traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            a = rnd_op();
            b = rnd_op();
            send(a, b, model(a, b));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        bif.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
            errors++;
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
